// File: rtl/tinyodin_pkg.sv
// rtl/tinyodin_pkg.sv - shared neuron-word layout, event types and sequencer states
// Purpose: constants and types imported by the neuron update sequencer.
// Ports: none (package).
package tinyodin_pkg;

    // Neuron SRAM word layout
    localparam int STATE_LSB = 0;
    localparam int STATE_W   = 12;
    localparam int LEAK_LSB  = 12;
    localparam int LEAK_W    = 7;
    localparam int THR_LSB   = 19;
    localparam int THR_W     = 12;
    localparam int DIS_BIT   = 31;

    // Input event types
    localparam logic EVT_SYN  = 1'b0;
    localparam logic EVT_TREF = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/lif_neuron_charge.sv
// rtl/lif_neuron_charge.sv - combinational leaky integrate-and-fire charge update
// Purpose: computes the next membrane state and spike flag for one neuron.
// Ports:
//   state_core      in  12  current membrane state (two's complement)
//   leak_str        in   7  leak magnitude applied on time-reference events
//   thr             in  12  firing threshold (unsigned)
//   syn_weight      in   4  signed synaptic weight
//   syn_event       in   1  an update is requested
//   time_ref        in   1  1 = leak toward zero, 0 = integrate weight
//   state_core_next out 12  updated state (zero after a spike)
//   spike_out       out  1  updated state reached the threshold
module lif_neuron_charge (
    input  logic [11:0] state_core,
    input  logic [6:0]  leak_str,
    input  logic [11:0] thr,
    input  logic [3:0]  syn_weight,
    input  logic        syn_event,
    input  logic        time_ref,
    output logic [11:0] state_core_next,
    output logic        spike_out
);

    localparam logic signed [12:0] SAT_HI = 13'sd2047;
    localparam logic signed [12:0] SAT_LO = -13'sd2048;

    // One guard bit is enough: |state| <= 2048, |weight| <= 8, leak <= 127
    logic signed [12:0] s_ext;
    logic signed [12:0] w_ext;
    logic signed [12:0] l_ext;
    logic signed [12:0] t_ext;
    logic signed [12:0] upd;

    always_comb begin
        s_ext     = {state_core[11], state_core};
        w_ext     = {{9{syn_weight[3]}}, syn_weight};
        l_ext     = {6'd0, leak_str};
        t_ext     = {1'b0, thr};
        upd       = s_ext;
        spike_out = 1'b0;
        if (syn_event) begin
            if (time_ref) begin
                // Leak pulls the state toward zero without crossing it
                if (s_ext > 13'sd0) begin
                    upd = s_ext - l_ext;
                    if (upd < 13'sd0) upd = 13'sd0;
                end else if (s_ext < 13'sd0) begin
                    upd = s_ext + l_ext;
                    if (upd > 13'sd0) upd = 13'sd0;
                end
            end else begin
                upd = s_ext + w_ext;
                if (upd > SAT_HI)      upd = SAT_HI;
                else if (upd < SAT_LO) upd = SAT_LO;
            end
            spike_out = (upd >= t_ext);
        end
        state_core_next = spike_out ? 12'd0 : upd[11:0];
    end

endmodule

// File: rtl/neuron_update_sequencer.sv
// rtl/neuron_update_sequencer.sv - event-driven scan of all neurons through the charge datapath
// Purpose: per accepted event, reads every neuron (and its synapse word for synaptic
//          events), applies lif_neuron_charge and writes the result back; spiking
//          addresses leave through a one-entry valid/ready register.
// Ports:
//   CLK, RST                       clock, asynchronous active-high reset
//   EVT_VALID/EVT_READY/TYPE/ADDR  input event handshake (TYPE 1 = time reference)
//   NRN_CS/WE/ADDR/WDATA/RDATA     neuron SRAM port (read data one cycle after read)
//   SYN_CS/ADDR/RDATA              synapse SRAM read port, eight 4-bit weights per word
//   SPK_VALID/READY/ADDR           spike output register
//   BUSY                           scan in progress
import tinyodin_pkg::*;

module neuron_update_sequencer #(
    parameter int N   = 256,
    parameter int AW  = 8,
    parameter int SAW = 13
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            EVT_VALID,
    output logic            EVT_READY,
    input  logic            EVT_TYPE,
    input  logic [AW-1:0]   EVT_ADDR,
    output logic            NRN_CS,
    output logic            NRN_WE,
    output logic [AW-1:0]   NRN_ADDR,
    output logic [31:0]     NRN_WDATA,
    input  logic [31:0]     NRN_RDATA,
    output logic            SYN_CS,
    output logic [SAW-1:0]  SYN_ADDR,
    input  logic [31:0]     SYN_RDATA,
    output logic            SPK_VALID,
    input  logic            SPK_READY,
    output logic [AW-1:0]   SPK_ADDR,
    output logic            BUSY
);

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   pre_q;
    logic            type_q;
    logic [31:0]     cap_word;
    logic [3:0]      cap_wt;
    logic [11:0]     state_next;
    logic            spike_out;
    logic            accept;
    logic            advance;
    logic            write_en;
    logic            last;
    logic            spk_valid_q;
    logic [AW-1:0]   spk_addr_q;

    lif_neuron_charge u_charge (
        .state_core      (cap_word[STATE_LSB +: STATE_W]),
        .leak_str        (cap_word[LEAK_LSB +: LEAK_W]),
        .thr             (cap_word[THR_LSB +: THR_W]),
        .syn_weight      (cap_wt),
        .syn_event       (1'b1),
        .time_ref        (type_q),
        .state_core_next (state_next),
        .spike_out       (spike_out)
    );

    assign last      = (cnt == AW'(N - 1));
    assign accept    = (state == IDLE) && EVT_VALID;
    assign BUSY      = (state != IDLE);
    assign SPK_VALID = spk_valid_q;
    assign SPK_ADDR  = spk_addr_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        EVT_READY = 1'b0;
        NRN_CS    = 1'b0;
        NRN_WE    = 1'b0;
        NRN_ADDR  = '0;
        NRN_WDATA = '0;
        SYN_CS    = 1'b0;
        SYN_ADDR  = '0;
        advance   = 1'b0;
        write_en  = 1'b0;
        case (state)
            IDLE: begin
                EVT_READY = !RST;
                if (EVT_VALID) state_nxt = RD;
            end
            RD: begin
                NRN_CS   = 1'b1;
                NRN_ADDR = cnt;
                if (type_q == EVT_SYN) begin
                    SYN_CS   = 1'b1;
                    SYN_ADDR = {pre_q, cnt[AW-1:3]};
                end
                state_nxt = CAP;
            end
            CAP: begin
                state_nxt = WR;
            end
            WR: begin
                if (cap_word[DIS_BIT]) begin
                    advance = 1'b1;
                end else if (!(spike_out && spk_valid_q && !SPK_READY)) begin
                    // A spike with the output register still full holds here unwritten
                    write_en  = 1'b1;
                    advance   = 1'b1;
                    NRN_CS    = 1'b1;
                    NRN_WE    = 1'b1;
                    NRN_ADDR  = cnt;
                    NRN_WDATA = {cap_word[DIS_BIT], cap_word[THR_LSB +: THR_W],
                                 cap_word[LEAK_LSB +: LEAK_W], state_next};
                end
                if (advance) state_nxt = last ? IDLE : RD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            pre_q    <= '0;
            type_q   <= 1'b0;
            cap_word <= '0;
            cap_wt   <= '0;
        end else begin
            if (accept) begin
                cnt    <= '0;
                pre_q  <= EVT_ADDR;
                type_q <= EVT_TYPE;
            end else if (advance && !last) begin
                cnt <= cnt + 1'b1;
            end
            if (state == CAP) begin
                cap_word <= NRN_RDATA;
                cap_wt   <= SYN_RDATA[{cnt[2:0], 2'b00} +: 4];
            end
        end
    end

    // Load takes priority over drain so a back-to-back spike is never lost
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            spk_valid_q <= 1'b0;
            spk_addr_q  <= '0;
        end else if (write_en && spike_out) begin
            spk_valid_q <= 1'b1;
            spk_addr_q  <= cnt;
        end else if (spk_valid_q && SPK_READY) begin
            spk_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_neuron_update_sequencer.sv
// tb/tb_neuron_update_sequencer.sv - self-checking bench for neuron_update_sequencer
module tb_neuron_update_sequencer;

    logic        CLK;
    logic        RST;
    logic        EVT_VALID;
    logic        EVT_READY;
    logic        EVT_TYPE;
    logic [7:0]  EVT_ADDR;
    logic        NRN_CS;
    logic        NRN_WE;
    logic [7:0]  NRN_ADDR;
    logic [31:0] NRN_WDATA;
    logic [31:0] NRN_RDATA;
    logic        SYN_CS;
    logic [12:0] SYN_ADDR;
    logic [31:0] SYN_RDATA;
    logic        SPK_VALID;
    logic        SPK_READY;
    logic [7:0]  SPK_ADDR;
    logic        BUSY;

    neuron_update_sequencer #(.N(256), .AW(8), .SAW(13)) dut (
        .CLK(CLK), .RST(RST),
        .EVT_VALID(EVT_VALID), .EVT_READY(EVT_READY), .EVT_TYPE(EVT_TYPE), .EVT_ADDR(EVT_ADDR),
        .NRN_CS(NRN_CS), .NRN_WE(NRN_WE), .NRN_ADDR(NRN_ADDR), .NRN_WDATA(NRN_WDATA), .NRN_RDATA(NRN_RDATA),
        .SYN_CS(SYN_CS), .SYN_ADDR(SYN_ADDR), .SYN_RDATA(SYN_RDATA),
        .SPK_VALID(SPK_VALID), .SPK_READY(SPK_READY), .SPK_ADDR(SPK_ADDR),
        .BUSY(BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mk(input logic dis, input logic [11:0] thr,
                                       input logic [6:0] leak, input logic [11:0] st);
        return {dis, thr, leak, st};
    endfunction

    localparam logic [31:0] DEF_WORD = {1'b0, 12'hFFF, 7'd0, 12'd0};

    // SRAM models; neuron memory and write counters are owned by this block only
    logic [31:0] nrn_mem [256];
    logic [31:0] syn_mem [8192];
    int          wr_count [256];
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic        fill_all;
    logic        clr_cnt;

    always @(posedge CLK) begin
        if (fill_all) for (int i = 0; i < 256; i++) nrn_mem[i] <= DEF_WORD;
        if (clr_cnt)  for (int i = 0; i < 256; i++) wr_count[i] <= 0;
        if (load_en) begin
            nrn_mem[load_addr] <= load_data;
        end else if (NRN_CS && NRN_WE) begin
            nrn_mem[NRN_ADDR]  <= NRN_WDATA;
            wr_count[NRN_ADDR] <= wr_count[NRN_ADDR] + 1;
        end
        if (NRN_CS && !NRN_WE) NRN_RDATA <= nrn_mem[NRN_ADDR];
        if (SYN_CS)            SYN_RDATA <= syn_mem[SYN_ADDR];
    end

    typedef struct {
        logic        typ;
        logic [7:0]  pre;
        logic [7:0]  nrn;
        logic [11:0] st;
        logic [6:0]  leak;
        logic [11:0] thr;
        logic [3:0]  wt;
        logic [11:0] exp_st;
        logic        exp_spk;
    } vec_t;

    vec_t       vecs [8];
    logic [7:0] exp_q [$];
    int         total;
    int         bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic load_nrn(input logic [7:0] a, input logic [31:0] d);
        @(posedge CLK); #1;
        load_en = 1'b1; load_addr = a; load_data = d;
        @(posedge CLK); #1;
        load_en = 1'b0;
    endtask

    task automatic pulse_clr();
        @(posedge CLK); #1;
        clr_cnt = 1'b1;
        @(posedge CLK); #1;
        clr_cnt = 1'b0;
    endtask

    task automatic send_event(input logic typ, input logic [7:0] addr);
        @(posedge CLK); #1;
        chk("evt_ready_idle", {31'd0, EVT_READY}, 32'd1);
        EVT_TYPE = typ; EVT_ADDR = addr; EVT_VALID = 1'b1;
        @(posedge CLK); #1;
        EVT_VALID = 1'b0;
        chk("busy_after_accept", {31'd0, BUSY}, 32'd1);
    endtask

    task automatic wait_idle(input int budget, output int cycles);
        cycles = 0;
        while (BUSY && cycles < budget) begin
            @(posedge CLK); #1;
            cycles++;
        end
        chk("scan_finished", {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        int          cyc;
        logic [12:0] sa;
        logic [31:0] word;
        total = 0; bad = 0;
        RST = 1'b1; EVT_VALID = 1'b1; EVT_TYPE = 1'b0; EVT_ADDR = 8'd0;
        SPK_READY = 1'b1;
        load_en = 1'b0; load_addr = 8'd0; load_data = 32'd0;
        fill_all = 1'b1; clr_cnt = 1'b1;
        for (int i = 0; i < 8192; i++) syn_mem[i] = 32'd0;

        // Scoreboard: every delivered spike must match the next expected address
        fork
            forever begin
                @(negedge CLK);
                if (!RST && SPK_VALID && SPK_READY) begin
                    if (exp_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL spk_unexpected actual=%0d expected=none", SPK_ADDR);
                    end else begin
                        chk("spk_addr", {24'd0, SPK_ADDR}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        join_none

        // Reset state with EVT_VALID held high
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_evt_ready", {31'd0, EVT_READY}, 32'd0);
        chk("rst_busy",      {31'd0, BUSY}, 32'd0);
        chk("rst_spk",       {23'd0, SPK_VALID, SPK_ADDR}, 32'd0);
        chk("rst_nrn_ctl",   {22'd0, NRN_CS, NRN_WE, NRN_ADDR}, 32'd0);
        chk("rst_nrn_wdata", NRN_WDATA, 32'd0);
        chk("rst_syn",       {18'd0, SYN_CS, SYN_ADDR}, 32'd0);
        fill_all = 1'b0; clr_cnt = 1'b0; EVT_VALID = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, EVT_READY}, 32'd1);
        chk("post_rst_busy",  {31'd0, BUSY}, 32'd0);

        //            typ pre   nrn     st       leak  thr      wt    exp_st   spk
        vecs[0] = '{1'b1, 8'd0, 8'd5,   12'd10,  7'd3,   12'd100, 4'd0, 12'd7,   1'b0};
        vecs[1] = '{1'b1, 8'd0, 8'd5,   12'hFFE, 7'd3,   12'd100, 4'd0, 12'h000, 1'b0};
        vecs[2] = '{1'b0, 8'd2, 8'd9,   12'd100, 7'd0,   12'd104, 4'd5, 12'd0,   1'b1};
        vecs[3] = '{1'b0, 8'd7, 8'd0,   12'h801, 7'd0,   12'd100, 4'h8, 12'h800, 1'b0};
        vecs[4] = '{1'b0, 8'd3, 8'd200, 12'd2040,7'd0,   12'hFFF, 4'd7, 12'h7FF, 1'b0};
        vecs[5] = '{1'b1, 8'd0, 8'd77,  12'd2,   7'd100, 12'd50,  4'd0, 12'd0,   1'b0};
        vecs[6] = '{1'b0, 8'd4, 8'd15,  12'hFFB, 7'd0,   12'd50,  4'd7, 12'd2,   1'b0};
        vecs[7] = '{1'b0, 8'd1, 8'd130, 12'd20,  7'd0,   12'd20,  4'd0, 12'd0,   1'b1};

        for (int v = 0; v < 8; v++) begin
            load_nrn(vecs[v].nrn, mk(1'b0, vecs[v].thr, vecs[v].leak, vecs[v].st));
            sa = {vecs[v].pre, vecs[v].nrn[7:3]};
            word = {28'd0, vecs[v].wt};
            syn_mem[sa] = word << (4 * vecs[v].nrn[2:0]);
            if (vecs[v].exp_spk) exp_q.push_back(vecs[v].nrn);
            send_event(vecs[v].typ, vecs[v].pre);
            wait_idle(2000, cyc);
            chk($sformatf("vec%0d_scan_cycles", v), cyc, 32'd768);
            chk($sformatf("vec%0d_word", v), nrn_mem[vecs[v].nrn],
                mk(1'b0, vecs[v].thr, vecs[v].leak, vecs[v].exp_st));
            chk($sformatf("vec%0d_neighbour", v), nrn_mem[vecs[v].nrn ^ 8'd1], DEF_WORD);
            @(posedge CLK); #1;
            chk($sformatf("vec%0d_spikes_left", v), exp_q.size(), 32'd0);
            syn_mem[sa] = 32'd0;
            load_nrn(vecs[v].nrn, DEF_WORD);
        end

        // Backpressure: neurons 3 and 4 spike with the output held; second pass disables 6
        for (int rep = 0; rep < 2; rep++) begin
            pulse_clr();
            SPK_READY = 1'b0;
            load_nrn(8'd3, mk(1'b0, 12'd104, 7'd0, 12'd100));
            load_nrn(8'd4, mk(1'b0, 12'd104, 7'd0, 12'd100));
            if (rep == 1) begin
                load_nrn(8'd6, mk(1'b1, 12'd104, 7'd0, 12'd100));
                syn_mem[13'd32] = 32'h0505_5000;
            end else begin
                syn_mem[13'd32] = 32'h0005_5000;
            end
            exp_q.push_back(8'd3);
            exp_q.push_back(8'd4);
            send_event(1'b0, 8'd1);
            repeat (40) @(posedge CLK);
            #1;
            chk($sformatf("bp%0d_stalled_busy", rep), {31'd0, BUSY}, 32'd1);
            chk($sformatf("bp%0d_held_spk", rep), {23'd0, SPK_VALID, SPK_ADDR}, {23'd0, 1'b1, 8'd3});
            chk($sformatf("bp%0d_no_wr4", rep), wr_count[4], 32'd0);
            chk($sformatf("bp%0d_wr3", rep), wr_count[3], 32'd1);
            chk($sformatf("bp%0d_no_wr5", rep), wr_count[5], 32'd0);
            SPK_READY = 1'b1;
            wait_idle(2000, cyc);
            @(posedge CLK); #1;
            chk($sformatf("bp%0d_spikes_left", rep), exp_q.size(), 32'd0);
            chk($sformatf("bp%0d_word3", rep), nrn_mem[3], mk(1'b0, 12'd104, 7'd0, 12'd0));
            chk($sformatf("bp%0d_word4", rep), nrn_mem[4], mk(1'b0, 12'd104, 7'd0, 12'd0));
            chk($sformatf("bp%0d_wr4", rep), wr_count[4], 32'd1);
            if (rep == 1) begin
                chk("bp_dis_no_wr6", wr_count[6], 32'd0);
                chk("bp_dis_word6", nrn_mem[6], mk(1'b1, 12'd104, 7'd0, 12'd100));
            end
            syn_mem[13'd32] = 32'd0;
            load_nrn(8'd3, DEF_WORD);
            load_nrn(8'd4, DEF_WORD);
            load_nrn(8'd6, DEF_WORD);
        end

        // Reset mid-scan: neuron 2 already written, neuron 200 never reached
        pulse_clr();
        load_nrn(8'd2,   mk(1'b0, 12'd100, 7'd3, 12'd10));
        load_nrn(8'd200, mk(1'b0, 12'd100, 7'd3, 12'd10));
        send_event(1'b1, 8'd0);
        repeat (20) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("midrst_busy",    {31'd0, BUSY}, 32'd0);
        chk("midrst_nrn_ctl", {22'd0, NRN_CS, NRN_WE, NRN_ADDR}, 32'd0);
        chk("midrst_ready",   {31'd0, EVT_READY}, 32'd0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("midrst_word2",   nrn_mem[2], mk(1'b0, 12'd100, 7'd3, 12'd7));
        chk("midrst_word200", nrn_mem[200], mk(1'b0, 12'd100, 7'd3, 12'd10));
        chk("midrst_no_wr200", wr_count[200], 32'd0);
        chk("midrst_ready_after", {31'd0, EVT_READY}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuron_update_sequencer.md
Name: neuron_update_sequencer

Overview:
- Event-driven controller directly upstream of the lif_neuron_charge datapath.
- Accepts one input event (synaptic or time-reference), scans all N neurons, reads neuron and synapse SRAM, applies the charge update, and writes the new state back.
- Spiking neuron addresses go out through a one-entry valid/ready register toward the AER output.

Parameters:
- N, 256, number of neurons; must be a multiple of 8.
- AW, 8, neuron address width; equals clog2(N).
- SAW, 13, synapse SRAM address width; equals AW + clog2(N/8).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- EVT_VALID  in  1  input event valid.
- EVT_READY  out  1  input event accepted; high only in IDLE.
- EVT_TYPE  in  1  event type: 0 = synaptic, 1 = time reference (leak).
- EVT_ADDR  in  AW  pre-synaptic neuron address; ignored when EVT_TYPE = 1.
- NRN_CS  out  1  neuron SRAM chip select.
- NRN_WE  out  1  neuron SRAM write enable.
- NRN_ADDR  out  AW  neuron SRAM address.
- NRN_WDATA  out  32  neuron SRAM write word.
- NRN_RDATA  in  32  neuron SRAM read word; valid 1 cycle after a read.
- SYN_CS  out  1  synapse SRAM chip select; read-only port.
- SYN_ADDR  out  SAW  synapse SRAM address = {pre_addr, j[AW-1:3]}.
- SYN_RDATA  in  32  synapse SRAM word holding eight 4-bit weights.
- SPK_VALID  out  1  spike output valid.
- SPK_READY  in  1  downstream ready.
- SPK_ADDR  out  AW  address of the spiking neuron.
- BUSY  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Neuron word layout:
  - [11:0] state_core (two's complement).
  - [18:12] leak_str.
  - [30:19] thr.
  - [31] disable.
- Weight for neuron j: SYN_RDATA[4*(j%8)+3 : 4*(j%8)], signed 4-bit.
- Reset (asynchronous, RST high):
  - FSM goes to IDLE; neuron counter = 0.
  - SPK_VALID = 0, SPK_ADDR = 0.
  - NRN_CS = NRN_WE = SYN_CS = 0; NRN_ADDR = 0, NRN_WDATA = 0, SYN_ADDR = 0.
  - BUSY = 0; EVT_READY = 0 while RST is high.
  - Reset mid-scan aborts the scan at once. No write completes after RST rises; neurons already written keep their new values.
- FSM states: IDLE, RD, CAP, WR.
- IDLE:
  - EVT_READY = 1.
  - On EVT_VALID: latch type and address, set cnt = 0, go to RD.
- RD:
  - Assert NRN_CS with NRN_WE = 0 and NRN_ADDR = cnt.
  - SYN_CS = 1 only for synaptic events.
  - Go to CAP.
- CAP:
  - Register NRN_RDATA and the selected weight.
  - Go to WR.
- WR:
  - Drive the registered values into lif_neuron_charge with syn_event = 1 and time_ref = latched type.
  - If disable = 1: no write, no spike; advance.
  - Else, if spike_out = 1 and the spike register is still occupied (SPK_VALID = 1 and SPK_READY = 0): stall in WR with no write.
  - Else: write NRN_WDATA = {disable, thr, leak_str, state_core_next} to cnt. On spike, load SPK_ADDR = cnt and set SPK_VALID = 1. Advance.
- Advance: if cnt == N-1, go to IDLE; else cnt++ and go to RD.
- Throughput: 3 cycles per neuron without stalls; a full scan takes 3N cycles from acceptance to return to IDLE.
- Spike register:
  - Cleared on SPK_VALID & SPK_READY.
  - Load and drain in the same cycle is allowed; the load wins and SPK_VALID stays 1.
  - SPK_ADDR stays stable while SPK_VALID = 1 and SPK_READY = 0.
- A new event is never accepted during a scan; EVT_VALID is simply held off.

Decomposition:
- Package tinyodin_pkg holds:
  - the neuron-word field offsets and widths;
  - the event-type constants EVT_SYN and EVT_TREF;
  - the FSM state enum.
- One sub-module: the existing lif_neuron_charge, instantiated unmodified as the combinational update datapath.

Test Plan:
- Reset values: hold RST with EVT_VALID = 1 -> all outputs 0 and EVT_READY = 0. After release -> EVT_READY = 1 and BUSY = 0.
- Leak, positive state: TREF event, neuron 5 with state 10, leak 3, thr 100 -> neuron 5 written with state 7. Scan takes 768 cycles (N = 256) and produces no spikes.
- Leak, negative state: TREF event, neuron 5 with state 0xFFE, leak 3 -> state 0x000.
- Synaptic spike: pre = 2, neuron 9 with state 100, thr 104, weight +5 at word 1, nibble 1 -> state 0 written, SPK_VALID = 1, SPK_ADDR = 9.
- Negative saturation: neuron 0 with state 0x801, weight -8 -> state 0x800 written, no spike.
- Backpressure and disable: neurons 3 and 4 both spike while SPK_READY = 0 -> FSM stalls in WR for neuron 4 with no write. Raise SPK_READY -> spike 3 then spike 4 are delivered. Repeat with neuron 6 disabled -> no write to 6, no spike from 6.
